// File: rtl/calc_cmd_packer.sv
// calc_cmd_packer
//   Host-side transmitter for the calc operand stream. Captures one command
//   (a, b, app, sel) and writes it as a 5-word, 48-bit frame into the FIFO
//   that feeds calc.datain. The FIFO full flag throttles the writes. Each
//   frame carries a 16-bit sequence number and a checksum, so the receiver
//   can detect framing loss.
//
//   Frame: W0 = {SYNC_BYTE, 5'b0, app, 7'b0, sel, 8'd4, seq}
//          W1 = a[79:32]   W2 = {a[31:0], b[79:64]}   W3 = b[63:16]
//          W4 = {b[15:0], 16'h0000, chk}
//          chk = XOR of every 16-bit lane of W0..W3, XORed with b[15:0]
//
// Handshake: cmd_valid/cmd_ready follow strict valid/ready semantics. The
//   command transfers on the rising edge where both are high. The host must
//   hold cmd_valid and the command stable until that edge. cmd_ready never
//   depends on cmd_valid.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   cmd_a, cmd_b        80-bit operands
//   cmd_app, cmd_sel    operation code / select
//   cmd_valid/ready     command handshake
//   full                FIFO full (sampled every cycle in SEND)
//   dataout, wren       registered FIFO write data / strobe
//   busy                frame in progress (capture through GAP)
//   frame_done          one-cycle pulse on the edge after W4 is written
module calc_cmd_packer #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] cmd_a,
  input  logic [79:0] cmd_b,
  input  logic [2:0]  cmd_app,
  input  logic        cmd_sel,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        full,
  output logic [47:0] dataout,
  output logic        wren,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  localparam logic [3:0] GAP_N     = 4'(GAP_CYCLES);
  localparam logic [2:0] LAST_IDX  = 3'd4;
  // idx 5 is a non-writing step after W4. It produces the frame_done pulse and
  // the seq increment one edge after the last write.
  localparam logic [2:0] FLUSH_IDX = 3'd5;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  gap_q, gap_d;
  logic [15:0] seq;

  logic [79:0] a_q, b_q;
  logic [2:0]  app_q;
  logic        sel_q;

  logic        accept;
  logic        wr_d, done_d;
  logic [47:0] w0, w1, w2, w3, w4, word;
  logic [15:0] chk;

  assign accept = cmd_valid && cmd_ready;

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      gap_q      <= 4'd0;
      seq        <= 16'd0;
      a_q        <= 80'd0;
      b_q        <= 80'd0;
      app_q      <= 3'd0;
      sel_q      <= 1'b0;
      dataout    <= 48'd0;
      wren       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      wren       <= wr_d;
      frame_done <= done_d;
      // dataout holds its last value while the FIFO stalls the frame
      if (wr_d)   dataout <= word;
      if (done_d) seq     <= seq + 16'd1;
      if (accept) begin
        a_q   <= cmd_a;
        b_q   <= cmd_b;
        app_q <= cmd_app;
        sel_q <= cmd_sel;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          idx_d   = 3'd0;
        end
      end
      SEND: begin
        if (idx_q == FLUSH_IDX) begin
          state_d = (GAP_N == 4'd0) ? IDLE : GAP;
          idx_d   = 3'd0;
          gap_d   = GAP_N;
        end else if (!full) begin
          idx_d = idx_q + 3'd1;
        end
      end
      GAP: begin
        if (gap_q <= 4'd1) begin
          state_d = IDLE;
          gap_d   = 4'd0;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
        gap_d   = 4'd0;
      end
    endcase
  end

  // Output / datapath logic
  always_comb begin
    w0  = {SYNC_BYTE, 5'b0, app_q, 7'b0, sel_q, 8'd4, seq};
    w1  = a_q[79:32];
    w2  = {a_q[31:0], b_q[79:64]};
    w3  = b_q[63:16];
    chk = w0[47:32] ^ w0[31:16] ^ w0[15:0]
        ^ w1[47:32] ^ w1[31:16] ^ w1[15:0]
        ^ w2[47:32] ^ w2[31:16] ^ w2[15:0]
        ^ w3[47:32] ^ w3[31:16] ^ w3[15:0]
        ^ b_q[15:0];
    w4  = {b_q[15:0], 16'h0000, chk};
    case (idx_q)
      3'd1:    word = w1;
      3'd2:    word = w2;
      3'd3:    word = w3;
      3'd4:    word = w4;
      default: word = w0;
    endcase
    // The decision uses the full flag of this cycle, so a write is never
    // issued from a cycle in which full is high.
    wr_d      = (state_q == SEND) && (idx_q <= LAST_IDX) && !full;
    done_d    = (state_q == SEND) && (idx_q == FLUSH_IDX);
    busy      = (state_q != IDLE);
    // cmd_ready is forced low while rst is asserted. It rises as soon as rst
    // is released.
    cmd_ready = !rst && (state_q == IDLE) && (gap_q == 4'd0);
  end

endmodule

// File: tb/tb_calc_cmd_packer.sv
// Testbench for calc_cmd_packer: table-driven frames, a scoreboard of expected
// FIFO words, a receiver-side checksum check and hand-written corner cases
// (reset, back-pressure, seq wrap, gap, mid-frame reset).
module tb_calc_cmd_packer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [79:0] cmd_a = '0, cmd_b = '0;
  logic [2:0]  cmd_app = '0;
  logic        cmd_sel = 1'b0;
  logic        cmd_valid = 1'b0, full = 1'b0;
  logic        cmd_ready0, wren0, busy0, frame_done0;
  logic [47:0] dataout0;

  logic        cmd_valid3 = 1'b0, full3 = 1'b0;
  logic        cmd_ready3, wren3, busy3, frame_done3;
  logic [47:0] dataout3;

  calc_cmd_packer #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_app(cmd_app),
    .cmd_sel(cmd_sel), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
    .full(full), .dataout(dataout0), .wren(wren0), .busy(busy0),
    .frame_done(frame_done0));

  calc_cmd_packer #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_app(cmd_app),
    .cmd_sel(cmd_sel), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .full(full3), .dataout(dataout3), .wren(wren3), .busy(busy3),
    .frame_done(frame_done3));

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame builder
  function automatic logic [239:0] build_frame(input logic [79:0] a, input logic [79:0] b,
                                               input logic [2:0] app, input logic sel,
                                               input logic [15:0] sq);
    logic [47:0] w0, w1, w2, w3, w4;
    logic [15:0] c;
    w0 = {8'hA5, 5'b0, app, 7'b0, sel, 8'd4, sq};
    w1 = a[79:32];
    w2 = {a[31:0], b[79:64]};
    w3 = b[63:16];
    c  = b[15:0];
    for (int i = 0; i < 3; i++) c ^= w0[16*i +: 16] ^ w1[16*i +: 16] ^ w2[16*i +: 16] ^ w3[16*i +: 16];
    w4 = {b[15:0], 16'h0000, c};
    return {w0, w1, w2, w3, w4};
  endfunction

  // ---------------- scoreboard / monitor (dut0) ----------------
  logic [47:0] exp_q[$];
  logic [15:0] model_seq = 16'd0;
  logic [47:0] last_hdr = '0;
  logic [15:0] rx_chk = '0;
  int          wr_idx = 0;
  logic        done_exp = 1'b0;
  logic        cap_s, full_s;
  logic [239:0] cap_frame;

  always @(posedge clk) begin
    cap_s     = cmd_valid && cmd_ready0 && !rst;
    full_s    = full;
    cap_frame = build_frame(cmd_a, cmd_b, cmd_app, cmd_sel, model_seq);
    #1;
    if (rst) begin
      exp_q.delete();
      model_seq = 16'd0;
      wr_idx    = 0;
      done_exp  = 1'b0;
    end else begin
      check("frame_done_timing", 64'(frame_done0), 64'(done_exp));
      done_exp = 1'b0;
      if (wren0) begin
        check("wren_while_full", 64'(full_s), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(dataout0), 64'hDEAD);
        end else begin
          check("sb_word", 64'(dataout0), 64'(exp_q.pop_front()));
        end
        if (wr_idx == 0) begin
          last_hdr = dataout0;
          rx_chk   = 16'd0;
        end
        if (wr_idx < 4) begin
          rx_chk ^= dataout0[47:32] ^ dataout0[31:16] ^ dataout0[15:0];
          wr_idx++;
        end else begin
          // Receiver-side verification of the checksum of a completed frame
          check("rx_chk", 64'(dataout0[15:0]), 64'(rx_chk ^ dataout0[47:32]));
          wr_idx   = 0;
          done_exp = 1'b1;
        end
      end
    end
    if (cap_s) begin
      for (int k = 4; k >= 0; k--) exp_q.push_back(cap_frame[48*k +: 48]);
      model_seq = model_seq + 16'd1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready0();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 64'd0, 64'd1);
  endtask

  // Sends one command to dut0, then drives full from mask (bit j = cycle j
  // after capture). len returns the number of edges from capture to frame_done.
  task automatic run_frame(input logic [79:0] a, input logic [79:0] b, input logic [2:0] app,
                           input logic sel, input logic [15:0] mask, output int len);
    wait_ready0();
    cmd_a = a; cmd_b = b; cmd_app = app; cmd_sel = sel; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    len = -1;
    for (int j = 0; j < 40; j++) begin
      full = (j < 16) ? mask[j] : 1'b0;
      @(posedge clk);
      #1;
      if (frame_done0) begin
        len = j + 1;
        break;
      end
    end
    full = 1'b0;
    if (len < 0) check("frame_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    logic [79:0] a;
    logic [79:0] b;
    logic [2:0]  app;
    logic        sel;
    logic [15:0] mask;
    int          exp_len;
  } vec_t;

  vec_t vecs[5];
  int   len;
  logic [47:0] lit[5];
  int   n;

  initial begin
    // table: inputs, full pattern and the expected capture-to-frame_done length
    vecs[0] = '{80'h1, 80'h2, 3'd1, 1'b0, 16'h0000, 6};
    vecs[1] = '{80'h0123_4567_89AB_CDEF_1357, 80'hFEDC_BA98_7654_3210_2468, 3'd5, 1'b1, 16'h001C, 9};
    vecs[2] = '{{$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 3'd7, 1'b1, 16'h0001, 7};
    vecs[3] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'h0, 3'd2, 1'b0, 16'h0055, 10};
    vecs[4] = '{{$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'h0010, 7};

    // ---- reset with cmd_valid held high ----
    cmd_valid = 1'b1;
    cmd_valid3 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_wren", 64'(wren0), 64'd0);
      check("rst_ready", 64'(cmd_ready0), 64'd0);
      check("rst_busy", 64'(busy0), 64'd0);
      check("rst_ready_gap", 64'(cmd_ready3), 64'd0);
    end
    check("rst_dataout", 64'(dataout0), 64'd0);
    check("rst_frame_done", 64'(frame_done0), 64'd0);
    cmd_valid = 1'b0;
    cmd_valid3 = 1'b0;
    rst = 1'b0;
    #1 check("ready_after_rst", 64'(cmd_ready0), 64'd1);

    // ---- basic frame, cycle-exact ----
    lit[0] = 48'hA501_0004_0000;
    lit[1] = 48'h0;
    lit[2] = 48'h0000_0001_0000;
    lit[3] = 48'h0;
    lit[4] = 48'h0002_0000_A506;
    @(negedge clk);
    cmd_a = 80'h1; cmd_b = 80'h2; cmd_app = 3'd1; cmd_sel = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("cap_busy", 64'(busy0), 64'd1);
    check("cap_ready_drop", 64'(cmd_ready0), 64'd0);
    check("cap_wren", 64'(wren0), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("basic_wren%0d", k), 64'(wren0), 64'd1);
      check($sformatf("basic_w%0d", k), 64'(dataout0), 64'(lit[k]));
    end
    @(posedge clk);
    #1;
    check("basic_done", 64'(frame_done0), 64'd1);
    check("basic_wren_end", 64'(wren0), 64'd0);
    @(posedge clk);
    #1 check("basic_done_pulse", 64'(frame_done0), 64'd0);

    // ---- table-driven frames with back-pressure ----
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].a, vecs[i].b, vecs[i].app, vecs[i].sel, vecs[i].mask, len);
      check($sformatf("vec%0d_len", i), 64'(len), 64'(vecs[i].exp_len));
    end
    repeat (2) @(posedge clk);
    #1 check("table_sb_empty", 64'(exp_q.size()), 64'd0);

    // ---- seq wrap ----
    @(negedge clk);
    force dut0.seq = 16'hFFFF;
    model_seq = 16'hFFFF;
    @(negedge clk);
    release dut0.seq;
    run_frame(80'hAAAA, 80'h5555, 3'd3, 1'b1, 16'h0000, len);
    check("wrap_hdr_ffff", 64'(last_hdr[15:0]), 64'hFFFF);
    run_frame(80'h1234, 80'h4321, 3'd4, 1'b0, 16'h0000, len);
    check("wrap_hdr_0000", 64'(last_hdr[15:0]), 64'h0000);

    // ---- gap: cmd_valid held on the GAP_CYCLES=3 instance ----
    @(negedge clk);
    cmd_valid3 = 1'b1;
    n = 0;
    while (!frame_done3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("gap_done_seen", 64'(frame_done3), 64'd1);
    check("gap_busy", 64'(busy3), 64'd1);
    n = 0;
    while (!cmd_ready3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_valid3 = 1'b0;
    check("gap_ready_low_cycles", 64'(n), 64'd3);

    // ---- mid-frame reset after W2 ----
    wait_ready0();
    cmd_a = 80'hBEEF; cmd_b = 80'hCAFE; cmd_app = 3'd6; cmd_sel = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_wren", 64'(wren0), 64'd0);
    check("midrst_busy", 64'(busy0), 64'd0);
    check("midrst_ready", 64'(cmd_ready0), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_frame(80'h7777, 80'h8888, 3'd1, 1'b1, 16'h0002, len);
    check("midrst_len", 64'(len), 64'd7);
    check("midrst_seq0", 64'(last_hdr[15:0]), 64'h0000);
    check("midrst_sync", 64'(last_hdr[47:40]), 64'hA5);

    repeat (3) @(posedge clk);
    #1 check("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
